// File: rtl/prod_accum_pkg.sv
// Shared state encoding and default sizing
// for the product accumulator.
package prod_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_ACC_W      = 16;
  localparam int DEF_N_PRODUCTS = 4;

endpackage

// File: rtl/sat_add.sv
// Unsigned W-bit adder that clips at all-ones
// and flags any clipped result.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    ovf = raw[W];
    sum = ovf ? '1 : raw[W-1:0];
  end

endmodule

// File: rtl/prod_accum.sv
// Sums batches of N_PRODUCTS multiplier products
// and holds each saturating result until consumed.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N_PRODUCTS = DEF_N_PRODUCTS,
  parameter int ACC_W      = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_product,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [7:0]       count
);

  // 9-bit count so a 256-product batch can reach its limit
  localparam logic [8:0] LAST = 9'(N_PRODUCTS);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] sum, out_sum_n;
  logic [8:0]       cnt, cnt_n;
  logic             sticky, sticky_n;
  logic             ovf;
  logic             out_sat_n, out_valid_n;
  logic             accept, fire;

  sat_add #(
    .W(ACC_W)
  ) u_add (
    .a  (acc),
    .b  ({{(ACC_W-8){1'b0}}, in_product}),
    .sum(sum),
    .ovf(ovf)
  );

  assign in_ready = ena && (state == ACCUM) && !clear;
  assign accept   = in_valid && in_ready;
  assign fire     = ena && !clear && (state == HOLD)
                    && out_valid && out_ready;
  assign count    = cnt[7:0];

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    sticky_n    = sticky;
    out_sum_n   = out_sum;
    out_sat_n   = out_sat;
    out_valid_n = out_valid;
    unique case (1'b1)
      clear: begin
        state_n     = ACCUM;
        acc_n       = '0;
        cnt_n       = '0;
        sticky_n    = 1'b0;
        out_sum_n   = '0;
        out_sat_n   = 1'b0;
        out_valid_n = 1'b0;
      end
      accept: begin
        acc_n    = sum;
        cnt_n    = cnt + 9'd1;
        sticky_n = sticky | ovf;
        if (cnt_n == LAST) begin
          out_sum_n   = sum;
          out_sat_n   = sticky_n;
          out_valid_n = 1'b1;
          state_n     = HOLD;
        end
      end
      fire: begin
        state_n     = ACCUM;
        acc_n       = '0;
        cnt_n       = '0;
        sticky_n    = 1'b0;
        out_valid_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      sticky    <= sticky_n;
      out_sum   <= out_sum_n;
      out_sat   <= out_sat_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench: three parameterisations driven in turn,
// expected batch results queued by a saturating model.
module tb_prod_accum;

  typedef struct {
    logic [31:0] sum;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_ena, a_clear, a_iv, a_or;
  logic        a_ir, a_ov, a_sat;
  logic [7:0]  a_prod, a_cnt;
  logic [15:0] a_sum;

  logic        b_ena, b_clear, b_iv, b_or;
  logic        b_ir, b_ov, b_sat;
  logic [7:0]  b_prod, b_cnt;
  logic [9:0]  b_sum;

  logic        c_ena, c_clear, c_iv, c_or;
  logic        c_ir, c_ov, c_sat;
  logic [7:0]  c_prod, c_cnt;
  logic [15:0] c_sum;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] m_sum;
  logic        m_sat;
  int          m_cnt;

  prod_accum u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .clear(a_clear),
    .in_valid(a_iv), .in_product(a_prod), .in_ready(a_ir),
    .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum),
    .out_sat(a_sat), .count(a_cnt)
  );

  prod_accum #(.N_PRODUCTS(8), .ACC_W(10)) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .clear(b_clear),
    .in_valid(b_iv), .in_product(b_prod), .in_ready(b_ir),
    .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum),
    .out_sat(b_sat), .count(b_cnt)
  );

  prod_accum #(.N_PRODUCTS(1), .ACC_W(16)) u_c (
    .clk(clk), .rst(rst), .ena(c_ena), .clear(c_clear),
    .in_valid(c_iv), .in_product(c_prod), .in_ready(c_ir),
    .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum),
    .out_sat(c_sat), .count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = '0;
    m_sat = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_add(input logic [7:0] p, input int w,
                           input int n);
    logic [32:0] s;
    logic [32:0] mx;
    exp_t x;
    mx = (33'd1 << w) - 33'd1;
    s  = {1'b0, m_sum} + 33'(p);
    if (s > mx) begin
      s     = mx;
      m_sat = 1'b1;
    end
    m_sum = s[31:0];
    m_cnt++;
    if (m_cnt == n) begin
      x.sum = m_sum;
      x.sat = m_sat;
      q.push_back(x);
      model_reset();
    end
  endtask

  task automatic pop_exp(output exp_t x);
    if (q.size() == 0) begin
      x.sum = 32'hdead_beef;
      x.sat = 1'bx;
    end else begin
      x = q.pop_front();
    end
  endtask

  task automatic a_acc(input logic [7:0] p);
    @(negedge clk);
    chk("a_in_ready", 32'(a_ir), 32'd1);
    a_iv   = 1'b1;
    a_prod = p;
    model_add(p, 16, 4);
    @(posedge clk);
    #1;
    a_iv = 1'b0;
  endtask

  task automatic a_collect(input string tag);
    exp_t x;
    int n;
    n = 0;
    while (!a_ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(a_ov), 32'd1);
    pop_exp(x);
    chk({tag, "_sum"}, 32'(a_sum), x.sum);
    chk({tag, "_sat"}, 32'(a_sat), 32'(x.sat));
    @(negedge clk);
    a_or = 1'b1;
    @(posedge clk);
    #1;
    a_or = 1'b0;
    chk({tag, "_ov_drop"}, 32'(a_ov), 32'd0);
    chk({tag, "_cnt_zero"}, 32'(a_cnt), 32'd0);
  endtask

  initial begin
    exp_t x;
    rst = 1'b1;
    a_ena = 1'b1; a_clear = 1'b0; a_iv = 1'b0; a_or = 1'b0;
    b_ena = 1'b1; b_clear = 1'b0; b_iv = 1'b0; b_or = 1'b0;
    c_ena = 1'b1; c_clear = 1'b0; c_iv = 1'b0; c_or = 1'b0;
    a_prod = '0; b_prod = '0; c_prod = '0;
    model_reset();
    #12;
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_sum", 32'(a_sum), 32'd0);
    chk("rst_sat", 32'(a_sat), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(a_ir), 32'd1);

    // four back-to-back products, then a long stall in HOLD
    a_acc(8'd15); a_acc(8'd30); a_acc(8'd45); a_acc(8'd225);
    chk("b2b_valid", 32'(a_ov), 32'd1);
    chk("b2b_cnt", 32'(a_cnt), 32'd4);
    pop_exp(x);
    chk("b2b_sum", 32'(a_sum), x.sum);
    chk("b2b_sat", 32'(a_sat), 32'(x.sat));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_iv = 1'b1;
      a_prod = 8'd99;
      #1;
      chk("hold_ready", 32'(a_ir), 32'd0);
      chk("hold_sum", 32'(a_sum), 32'd315);
      chk("hold_valid", 32'(a_ov), 32'd1);
    end
    @(negedge clk);
    a_or = 1'b1;
    @(posedge clk);
    #1;
    a_or = 1'b0;
    a_iv = 1'b0;
    chk("hs_ov", 32'(a_ov), 32'd0);
    chk("hs_cnt", 32'(a_cnt), 32'd0);

    // clear on the third product drops it
    a_acc(8'd10); a_acc(8'd20);
    @(negedge clk);
    a_iv = 1'b1; a_prod = 8'd30; a_clear = 1'b1;
    #1;
    chk("clr_ready", 32'(a_ir), 32'd0);
    @(posedge clk);
    #1;
    a_iv = 1'b0; a_clear = 1'b0;
    model_reset();
    chk("clr_cnt", 32'(a_cnt), 32'd0);
    chk("clr_ov", 32'(a_ov), 32'd0);
    a_acc(8'd1); a_acc(8'd2); a_acc(8'd3); a_acc(8'd4);
    a_collect("after_clr");

    // enable low freezes a partial batch
    a_acc(8'd50); a_acc(8'd60);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_ena = 1'b0; a_iv = 1'b1; a_prod = 8'd77;
      #1;
      chk("ena_ready", 32'(a_ir), 32'd0);
      chk("ena_cnt", 32'(a_cnt), 32'd2);
    end
    @(negedge clk);
    a_ena = 1'b1; a_iv = 1'b0;
    a_acc(8'd70); a_acc(8'd80);
    a_collect("after_ena");

    // asynchronous reset mid-batch and in HOLD
    a_acc(8'd5); a_acc(8'd6);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_cnt", 32'(a_cnt), 32'd0);
    chk("rstmid_ready", 32'(a_ir), 32'd1);
    rst = 1'b0;
    model_reset();
    a_acc(8'd100); a_acc(8'd100); a_acc(8'd100); a_acc(8'd100);
    chk("pre_rst_ov", 32'(a_ov), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rsthold_ov", 32'(a_ov), 32'd0);
    chk("rsthold_sum", 32'(a_sum), 32'd0);
    chk("rsthold_cnt", 32'(a_cnt), 32'd0);
    chk("rsthold_ready", 32'(a_ir), 32'd1);
    rst = 1'b0;
    q.delete();
    model_reset();
    a_acc(8'd1); a_acc(8'd1); a_acc(8'd1); a_acc(8'd1);
    a_collect("after_rst");

    // narrow accumulator saturates
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_iv = 1'b1; b_prod = 8'd225;
      model_add(8'd225, 10, 8);
      @(posedge clk);
      #1;
      b_iv = 1'b0;
    end
    pop_exp(x);
    chk("sat_valid", 32'(b_ov), 32'd1);
    chk("sat_sum", 32'(b_sum), x.sum);
    chk("sat_flag", 32'(b_sat), 32'(x.sat));
    chk("sat_cnt", 32'(b_cnt), 32'd8);

    // single-product batches; clear beats handshake
    @(negedge clk);
    c_iv = 1'b1; c_prod = 8'd200;
    model_add(8'd200, 16, 1);
    @(posedge clk);
    #1;
    c_iv = 1'b0;
    pop_exp(x);
    chk("n1_valid", 32'(c_ov), 32'd1);
    chk("n1_sum", 32'(c_sum), x.sum);
    chk("n1_cnt", 32'(c_cnt), 32'd1);
    chk("n1_ready", 32'(c_ir), 32'd0);
    @(negedge clk);
    c_clear = 1'b1; c_or = 1'b1;
    @(posedge clk);
    #1;
    c_clear = 1'b0; c_or = 1'b0;
    chk("clrhs_ov", 32'(c_ov), 32'd0);
    chk("clrhs_sum", 32'(c_sum), 32'd0);
    @(negedge clk);
    c_iv = 1'b1; c_prod = 8'd17;
    model_add(8'd17, 16, 1);
    @(posedge clk);
    #1;
    c_iv = 1'b0;
    pop_exp(x);
    chk("n1b_sum", 32'(c_sum), x.sum);
    chk("n1b_valid", 32'(c_ov), 32'd1);
    @(negedge clk);
    c_or = 1'b1;
    @(posedge clk);
    #1;
    c_or = 1'b0;
    chk("n1b_hs", 32'(c_ov), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter N_PRODUCTS, default 4, meaning products summed per batch (legal range 1..256).
REQ-002 SHALL have parameter ACC_W, default 16, meaning accumulator/result width (legal range 10..32).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ena, input, 1, design enable; low freezes all state except clear and reset.
REQ-006 SHALL have port clear, input, 1, synchronous batch abort.
REQ-007 SHALL have port in_valid, input, 1, upstream 4x4 multiplier product valid.
REQ-008 SHALL have port in_product, input, 8, unsigned product from the array multiplier.
REQ-009 SHALL have port in_ready, output, 1, block accepts a product this cycle.
REQ-010 SHALL have port out_valid, output, 1, batch sum available.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes the sum.
REQ-012 SHALL have port out_sum, output, ACC_W, registered batch sum.
REQ-013 SHALL have port out_sat, output, 1, batch saturated, valid with out_valid.
REQ-014 SHALL have port count, output, 8, products accepted in current batch.

Function
REQ-015 SHALL implement two states: ACCUM (collecting) and HOLD (result pending).
REQ-016 SHALL drive in_ready = ena AND (state == ACCUM) AND NOT clear, combinationally.
REQ-017 SHALL accept a product when in_valid AND in_ready are both high at a rising edge.
REQ-018 SHALL, on accept in ACCUM, add in_product zero-extended to ACC_W into acc and increment count.
REQ-019 SHALL saturate acc at 2^ACC_W-1, never wrapping, and set a sticky batch-saturation flag on any clipped add.
REQ-020 SHALL, on the accept that makes count equal N_PRODUCTS, load out_sum with the final sum, out_sat with the sticky flag, set out_valid, and enter HOLD on the same edge (sum visible the cycle after the last accept).
REQ-021 SHALL hold out_sum, out_sat, out_valid stable in HOLD until out_valid AND out_ready AND ena at an edge.
REQ-022 SHALL, on HOLD handshake completion, clear acc, count, sticky flag and out_valid and return to ACCUM; no product is accepted on that edge.
REQ-023 SHALL ignore in_valid in HOLD (in_ready low, no backpressure loss permitted upstream).
REQ-024 SHALL, with ena low, hold all state and ignore in_valid and out_ready.
REQ-025 SHALL, on clear high at an edge (regardless of ena or state), zero acc, count, sticky flag, out_sum, out_sat, out_valid and enter ACCUM; clear beats a simultaneous accept or handshake.
REQ-026 SHALL, with N_PRODUCTS = 1, enter HOLD on every accept.
REQ-027 SHALL report count as the current batch count, 0 after handshake, clear, or reset.

Reset
REQ-028 SHALL, on rst high, immediately force state ACCUM, acc 0, count 0, sticky 0, out_sum 0, out_sat 0, out_valid 0, independent of clk.
REQ-029 SHALL discard any partial batch or pending result when rst asserts mid-operation.
REQ-030 SHALL resume accepting on the first rising edge after rst deasserts.

Structure
REQ-031 SHALL place the state enumeration (ACCUM, HOLD) and default ACC_W/N_PRODUCTS constants in shared package prod_accum_pkg.
REQ-032 SHALL use one sub-module, sat_add, a combinational ACC_W-bit unsigned saturating adder with overflow flag output.
REQ-033 SHALL keep all outputs except in_ready registered.

Verification
REQ-034 SHALL cover: N=4, products 15,30,45,225 back-to-back -> out_valid one cycle after 4th accept, out_sum=315, out_sat=0, count=4.
REQ-035 SHALL cover: HOLD with out_ready low for 10 cycles and in_valid high -> out_sum stable, in_ready low, no product lost after handshake (next batch count starts at 0).
REQ-036 SHALL cover: ACC_W=10, N=8, all products 225 -> out_sum=1023, out_sat=1.
REQ-037 SHALL cover: clear asserted with in_valid on 3rd product -> product dropped, count=0, out_valid=0, next batch sums correctly.
REQ-038 SHALL cover: rst pulse mid-batch (between edges) and in HOLD -> outputs zero immediately, state ACCUM.
REQ-039 SHALL cover: ena low for 5 cycles with in_valid high mid-batch -> count and acc unchanged, in_ready low.
